// File: rtl/m92_pic_nested_if.sv
// Bus bundle for the M92 nested PIC: register port, CPU INT/INTA pins and raw IRQ inputs.
// master drives the register/ack/request side, slave is the controller itself.
interface m92_pic_nested_if #(
   parameter int N_IRQ = 8
);
   logic             ce_i;
   logic             cs_i;
   logic             wr_i;
   logic             rd_i;
   logic             a0_i;
   logic [7:0]       din_i;
   logic [7:0]       dout_o;
   logic             int_req_o;
   logic [7:0]       int_vector_o;
   logic             int_ack_i;
   logic [N_IRQ-1:0] intp_i;

   modport master (
      output ce_i, cs_i, wr_i, rd_i, a0_i, din_i, int_ack_i, intp_i,
      input  dout_o, int_req_o, int_vector_o
   );

   modport slave (
      input  ce_i, cs_i, wr_i, rd_i, a0_i, din_i, int_ack_i, intp_i,
      output dout_o, int_req_o, int_vector_o
   );
endinterface

// File: rtl/m92_pic_nested.sv
// V30-style nested-priority interrupt controller (IRR/ISR/IMW, EOI, auto-EOI, edge/level triggers).
// Optional macro M92_PIC_POLL_EN adds poll-mode reads that acknowledge without INTA.
//
// state      | meaning
// UNINIT     | after reset, ignores triggers and data writes
// INIT_IW2   | waiting for vector base (a0=1)
// INIT_IW3   | waiting for cascade word, discarded (no cascade)
// INIT_IW4   | waiting for mode word (bit1 = auto-EOI)
// INIT_DONE  | operational; a0=1 writes go to the mask
module m92_pic_nested #(
   parameter int         N_IRQ      = 8,
   parameter logic [7:0] LEVEL_MASK = 8'h00
) (
   input logic            clk,
   input logic            rst,
   m92_pic_nested_if.slave bus
);
   typedef enum logic [2:0] {UNINIT, INIT_IW2, INIT_IW3, INIT_IW4, INIT_DONE} state_t;

   localparam logic [7:0] CH_MASK = 8'((9'd1 << N_IRQ) - 9'd1);

   state_t     state_q, state_d;
   logic [7:0] irr_q, irr_d, isr_q, isr_d, imw_q, imw_d;
   logic       lvl_inv_q, lvl_inv_d, single_q, single_d, need_iw4_q, need_iw4_d;
   logic [4:0] base_q, base_d;
   logic       aeoi_q, aeoi_d;
   logic       ack_q, phase_q, phase_d;
   logic [7:0] intp_q, vec_q, vec_d, dout_q, dout_d;
   logic       rdsel_q, rdsel_d;
`ifdef M92_PIC_POLL_EN
   logic       poll_q, poll_d;
`endif

   logic [7:0] intp_w, trig_lvl, pend;
   logic [2:0] p, isr_low;
   logic       int_req;
   logic       wr_en, rd_en, iw1_wr, cmd_wr, dat_wr, eoi_wr, sel_wr;
   logic       ack_rise, ack2, poll_rd, take;

   always_comb begin
      intp_w = '0;
      intp_w[N_IRQ-1:0] = bus.intp_i;
      trig_lvl = (LEVEL_MASK ^ {8{lvl_inv_q}}) & CH_MASK;
      pend = irr_q & ~imw_q;
      p = 3'd0;
      for (int i = 7; i >= 0; i--) if (pend[i]) p = 3'(i);
      isr_low = 3'd0;
      for (int i = 7; i >= 0; i--) if (isr_q[i]) isr_low = 3'(i);
      int_req = (pend != 8'd0) && ((isr_q == 8'd0) || (p < isr_low));
   end

   assign wr_en    = bus.cs_i & bus.wr_i;
   assign rd_en    = bus.cs_i & bus.rd_i;
   assign iw1_wr   = wr_en & ~bus.a0_i & bus.din_i[4];
   assign cmd_wr   = wr_en & ~bus.a0_i & ~bus.din_i[4];
   assign dat_wr   = wr_en & bus.a0_i;
   assign eoi_wr   = cmd_wr & ~bus.din_i[3] & bus.din_i[5];
   assign sel_wr   = cmd_wr & bus.din_i[3];
   assign ack_rise = bus.int_ack_i & ~ack_q;
   assign ack2     = ack_rise & phase_q;
`ifdef M92_PIC_POLL_EN
   assign poll_rd  = rd_en & ~bus.a0_i & poll_q;
`else
   assign poll_rd  = 1'b0;
`endif
   assign take     = (ack2 | poll_rd) & int_req;

   always_comb begin
      state_d    = state_q;
      imw_d      = imw_q;
      lvl_inv_d  = lvl_inv_q;
      single_d   = single_q;
      need_iw4_d = need_iw4_q;
      base_d     = base_q;
      aeoi_d     = aeoi_q;
      rdsel_d    = rdsel_q;
      phase_d    = ack_rise ? ~phase_q : phase_q;
      vec_d      = vec_q;
      dout_d     = dout_q;
`ifdef M92_PIC_POLL_EN
      poll_d     = poll_q;
`endif

      // EOI works on the ISR as it stood before any same-cycle acknowledge
      isr_d = isr_q;
      if (eoi_wr) begin
         if (bus.din_i[6]) isr_d[bus.din_i[2:0]] = 1'b0;
         else if (isr_q != 8'd0) isr_d[isr_low] = 1'b0;
      end

      irr_d = irr_q;
      if (take) begin
         irr_d[p] = 1'b0;
         if (!aeoi_q) isr_d[p] = 1'b1;
      end
      if (ack2) vec_d = {base_q, (int_req ? p : 3'd7)};

      // triggers applied after the ack clear so a fresh request survives it
      if (state_q == INIT_DONE) begin
         for (int i = 0; i < 8; i++) begin
            if (trig_lvl[i]) irr_d[i] = intp_w[i];
            else if (intp_w[i] && !intp_q[i]) irr_d[i] = 1'b1;
         end
      end

      if (rd_en) dout_d = bus.a0_i ? imw_q : (rdsel_q ? isr_q : irr_q);
`ifdef M92_PIC_POLL_EN
      if (poll_rd) begin
         dout_d = {int_req, 4'b0000, p};
         poll_d = 1'b0;
      end
      if (sel_wr && bus.din_i[2]) poll_d = 1'b1;
`endif

      if (sel_wr && bus.din_i[1]) rdsel_d = bus.din_i[0];

      if (dat_wr) begin
         case (state_q)
            INIT_IW2: begin
               base_d  = bus.din_i[7:3];
               state_d = !single_q ? INIT_IW3 : (need_iw4_q ? INIT_IW4 : INIT_DONE);
            end
            INIT_IW3: state_d = need_iw4_q ? INIT_IW4 : INIT_DONE;
            INIT_IW4: begin
               aeoi_d  = bus.din_i[1];
               state_d = INIT_DONE;
            end
            INIT_DONE: imw_d = bus.din_i & CH_MASK;
            default: ;
         endcase
      end

      if (iw1_wr) begin
         lvl_inv_d  = bus.din_i[3];
         single_d   = bus.din_i[1];
         need_iw4_d = bus.din_i[0];
         irr_d      = '0;
         isr_d      = '0;
         imw_d      = '0;
         rdsel_d    = 1'b0;
         phase_d    = 1'b0;
         state_d    = INIT_IW2;
`ifdef M92_PIC_POLL_EN
         poll_d     = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UNINIT;
         irr_q      <= '0;
         isr_q      <= '0;
         imw_q      <= '0;
         lvl_inv_q  <= 1'b0;
         single_q   <= 1'b0;
         need_iw4_q <= 1'b0;
         base_q     <= '0;
         aeoi_q     <= 1'b0;
         ack_q      <= 1'b0;
         phase_q    <= 1'b0;
         intp_q     <= '0;
         vec_q      <= '0;
         dout_q     <= '0;
         rdsel_q    <= 1'b0;
`ifdef M92_PIC_POLL_EN
         poll_q     <= 1'b0;
`endif
      end else if (bus.ce_i) begin
         state_q    <= state_d;
         irr_q      <= irr_d;
         isr_q      <= isr_d;
         imw_q      <= imw_d;
         lvl_inv_q  <= lvl_inv_d;
         single_q   <= single_d;
         need_iw4_q <= need_iw4_d;
         base_q     <= base_d;
         aeoi_q     <= aeoi_d;
         ack_q      <= bus.int_ack_i;
         phase_q    <= phase_d;
         intp_q     <= intp_w;
         vec_q      <= vec_d;
         dout_q     <= dout_d;
         rdsel_q    <= rdsel_d;
`ifdef M92_PIC_POLL_EN
         poll_q     <= poll_d;
`endif
      end
   end

   assign bus.dout_o       = dout_q;
   assign bus.int_req_o    = int_req;
   assign bus.int_vector_o = vec_q;
endmodule
